// File: rtl/pattern_serializer.sv
// -----------------------------------------------------------------------------
// pattern_serializer
//
// Buffers parallel words in a small FIFO and shifts them out one bit per
// clock, MSB first. A word that finishes shifting is followed on the very next
// cycle by the next buffered word, so back-to-back words form one unbroken
// run of valid bits. The serial stream feeds a downstream pattern detector.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   din         parallel word to serialize
//   din_valid   din is presented this cycle
//   din_ready   FIFO can accept a word this cycle (combinational)
//   out         serial bit, MSB of the shift register while shifting, else 0
//   out_valid   out carries a data bit this cycle
//   busy        shifter active or FIFO non-empty
//   fifo_count  number of words held in the FIFO
//
// Shifter states
//   state | meaning
//   IDLE  | nothing in the shift register; out=0, out_valid=0
//   SHIFT | shreg MSB is on out; one bit leaves per clock
// -----------------------------------------------------------------------------
module pattern_serializer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic                         out,
    output logic                         out_valid,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;

    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                push;
    logic                pop;
    logic                fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign din_ready  = (count_q < DEPTH_C);
    assign push       = din_valid && din_ready;

    // -------------------------------------------------------------------------
    // Shifter FSM: next state, shift register and bit counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                // Pop decision uses the registered count, so a word pushed
                // this edge is not visible here: no bypass into the shifter.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (!fifo_empty) begin
                        // Reload on the last bit so out_valid has no gap.
                        pop       = 1'b1;
                        shreg_d   = mem_q[rd_ptr_q];
                        bit_cnt_d = '0;
                    end else begin
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end else begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO: pointers wrap naturally because FIFO_DEPTH is a power of two
    // -------------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs are decoded from registered state only, so the asynchronous
    // reset forces them low without waiting for a clock edge.
    assign out_valid  = (state_q == SHIFT);
    assign out        = out_valid && shreg_q[WORD_W-1];
    assign busy       = out_valid || !fifo_empty;
    assign fifo_count = count_q;

endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter WORD_W, default 8: width of each parallel word, sent MSB first.
REQ-002 Parameter FIFO_DEPTH, default 4: number of words buffered ahead of the shifter; power of two.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, regardless of clk.
REQ-005 din  input  WORD_W  parallel word to serialize.
REQ-006 din_valid  input  1  din is presented this cycle.
REQ-007 din_ready  output  1  FIFO can accept a word this cycle.
REQ-008 out  output  1  serial bit stream; feeds the downstream pattern detector input.
REQ-009 out_valid  output  1  out carries a data bit this cycle.
REQ-010 busy  output  1  shifter in SHIFT state or FIFO non-empty.
REQ-011 fifo_count  output  clog2(FIFO_DEPTH)+1  words currently held in the FIFO.

Function
REQ-012 Push occurs on a rising edge when din_valid=1 and din_ready=1; din is written at the FIFO tail.
REQ-013 din_ready shall be combinational: 1 when fifo_count < FIFO_DEPTH, else 0.
REQ-014 din_valid while din_ready=0 shall be ignored; no data is written and no state changes.
REQ-015 The shifter FSM has two states: IDLE and SHIFT.
REQ-016 IDLE with fifo_count=0 shall stay in IDLE, hold out=0 and out_valid=0.
REQ-017 IDLE with fifo_count>0 shall, on the edge, pop the head into the shift register, clear bit_cnt and enter SHIFT.
REQ-018 In SHIFT, out shall equal shreg[WORD_W-1] and out_valid=1; each edge shifts shreg left by one and increments bit_cnt.
REQ-019 When bit_cnt=WORD_W-1 and fifo_count>0, the edge shall pop the next word and restart at bit_cnt=0, with no gap in out_valid.
REQ-020 When bit_cnt=WORD_W-1 and fifo_count=0, the edge shall return to IDLE, and out_valid=0 on the following cycle.
REQ-021 A push and a pop on the same edge shall leave fifo_count unchanged and preserve word order.
REQ-022 A push into an empty FIFO while in IDLE has no bypass.
  - Word accepted at edge N.
  - First bit valid after edge N+1.
REQ-023 FIFO pointers shall wrap modulo FIFO_DEPTH; fifo_count shall never exceed FIFO_DEPTH or go below 0.
REQ-024 Each accepted word shall produce exactly WORD_W valid bits, in acceptance order.
REQ-025 busy = (state==SHIFT) OR (fifo_count>0).

Reset
REQ-026 While reset=0, the block shall be held in its reset state:
  - state=IDLE; shreg=0; bit_cnt=0.
  - FIFO pointers=0; fifo_count=0.
  - out=0; out_valid=0; busy=0.
  - din_ready=1.
REQ-027 Assertion mid-word shall abort the word in flight and discard all buffered words; no partial bits are emitted after release.
REQ-028 After reset deasserts, the first push shall be accepted on the first rising edge where din_valid=1.

Verification
REQ-029 Single word: reset low 100 ns, then push din=8'b1010_1110 once.
  - out_valid=1 for exactly 8 cycles.
  - out sequence 1,0,1,0,1,1,1,0.
  - Downstream detector sees 1010111.
REQ-030 Back-to-back: push 8'hA5 then 8'h3C on consecutive edges.
  - 16 contiguous out_valid cycles.
  - Bits 10100101 followed by 00111100, with no idle cycle between them.
REQ-031 Full: din_valid held high with the shifter draining.
  - Five words accepted: one in shreg, four in the FIFO.
  - din_ready=0 while fifo_count=4.
  - din_ready=1 on the cycle after the next pop.
REQ-032 Simultaneous push/pop at fifo_count=2: fifo_count stays 2 and word order is preserved at out.
REQ-033 Reset mid-shift: assert reset=0 after 3 bits of 8'hFF with 2 words buffered.
  - out=0, out_valid=0, fifo_count=0, busy=0 immediately, without waiting for a clock edge.
  - No further bits appear until a new push.
